// File: rtl/send_ctrl_if.sv
// ----------------------------------------------------------------------------
// send_ctrl_if
//   Bundles the frame handshake, result-RAM read port and UART sender port of
//   send_ctrl into one interface.
//
//   Signals:
//     start     frame request pulse (sampled by the controller in IDLE)
//     busy      frame in progress
//     done      one-cycle frame-complete pulse
//     rd_en     result-RAM read strobe
//     rd_addr   result-RAM address (AW bits)
//     rd_data   result-RAM data, valid one cycle after rd_en
//     tx_we     level write-enable towards send.we
//     tx_pixel  byte towards send.Pixel
//     tx_done   byte-complete pulse from send.sentFlag
//
//   Modports:
//     master  the sequencer (send_ctrl)
//     slave   its environment (frame requester, RAM, sender)
// ----------------------------------------------------------------------------
interface send_ctrl_if #(
    parameter int unsigned AW = 12
);
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          tx_we;
    logic [7:0]    tx_pixel;
    logic          tx_done;

    modport master (
        input  start,
        input  rd_data,
        input  tx_done,
        output busy,
        output done,
        output rd_en,
        output rd_addr,
        output tx_we,
        output tx_pixel
    );

    modport slave (
        output start,
        output rd_data,
        output tx_done,
        input  busy,
        input  done,
        input  rd_en,
        input  rd_addr,
        input  tx_we,
        input  tx_pixel
    );
endinterface

// File: rtl/send_ctrl.sv
// ----------------------------------------------------------------------------
// send_ctrl
//   Frame-level sequencer for the UART byte sender. On a start pulse it reads
//   NPIX pixels from the result RAM in address order and hands each one to the
//   sender with a level write-enable, fetching the next pixel only after the
//   sender reports completion of the current byte.
//
//   Optional feature (macro SEND_CTRL_CHECKSUM_EN):
//     defined   - an extra byte, the mod-256 sum of all frame pixels, is sent
//                 after the last pixel and before done.
//     undefined - exactly NPIX bytes are sent; no sum register exists.
//
//   Parameters:
//     NPIX  pixels per frame (1..4096)
//     AW    read-address width, 2**AW >= NPIX
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   send_ctrl_if.master: start/busy/done handshake, RAM read port
//           (rd_en/rd_addr/rd_data) and sender port (tx_we/tx_pixel/tx_done)
//
//   All outputs decode from registered state, the pixel register and the
//   index counter only; no input has a combinational path to an output.
// ----------------------------------------------------------------------------
module send_ctrl #(
    parameter int unsigned NPIX = 64,
    parameter int unsigned AW   = 12
) (
    input  logic        clk,
    input  logic        rst,
    send_ctrl_if.master bus
);

    // Index counter width: enough for NPIX-1, never narrower than one bit.
    localparam int unsigned   IW      = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NPIX - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StLatch = 3'd2;
    localparam logic [2:0] StSend  = 3'd3;
    localparam logic [2:0] StGap   = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;
`ifdef SEND_CTRL_CHECKSUM_EN
    localparam logic [2:0] StCsum  = 3'd6;
`endif

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [7:0]    pix_q,   pix_d;
`ifdef SEND_CTRL_CHECKSUM_EN
    logic [7:0]    sum_q,   sum_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
`ifdef SEND_CTRL_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    idx_d   = '0;
`ifdef SEND_CTRL_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = StFetch;
                end
            end

            StFetch: begin
                state_d = StLatch;
            end

            // RAM data is valid exactly one cycle after the read strobe.
            StLatch: begin
                pix_d   = bus.rd_data;
`ifdef SEND_CTRL_CHECKSUM_EN
                sum_d   = sum_q + bus.rd_data;
`endif
                state_d = StSend;
            end

            // tx_done in the very first SEND cycle is accepted as well.
            StSend: begin
                if (bus.tx_done) begin
                    state_d = StGap;
                end
            end

            // One cycle with tx_we low between bytes; this is also what keeps a
            // held tx_done from being counted twice for pixel bytes.
            StGap: begin
                if (idx_q == LastIdx) begin
`ifdef SEND_CTRL_CHECKSUM_EN
                    pix_d   = sum_q;
                    state_d = StCsum;
`else
                    state_d = StDone;
`endif
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = StFetch;
                end
            end

`ifdef SEND_CTRL_CHECKSUM_EN
            // Same handshake as SEND, with the checksum already in pix_q.
            StCsum: begin
                if (bus.tx_done) begin
                    state_d = StDone;
                end
            end
`endif

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
        end
    end

`ifdef SEND_CTRL_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs: pure decode of registered state. Because state_q resets
    // asynchronously, tx_we/busy/rd_en fall as soon as rst rises.
    // ------------------------------------------------------------------------
    logic tx_we;

    always_comb begin
        tx_we = (state_q == StSend);
`ifdef SEND_CTRL_CHECKSUM_EN
        tx_we = tx_we || (state_q == StCsum);
`endif
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.rd_en    = (state_q == StFetch);
    assign bus.rd_addr  = AW'(idx_q);
    assign bus.tx_we    = tx_we;
    assign bus.tx_pixel = pix_q;

endmodule

// File: tb/tb_send_ctrl.sv
// ----------------------------------------------------------------------------
// tb_send_ctrl
//   Self-checking bench for send_ctrl. Two instances: dut_a (NPIX=4) for the
//   main frame, timing, protocol-abuse and reset-mid-send scenarios, and
//   dut_b (NPIX=1) for the single-pixel frame with a held tx_done.
//   Expected bytes/addresses are queued when a frame is set up and compared
//   by per-instance monitors as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_send_ctrl;

    localparam int unsigned AW_A = 4;
    localparam int unsigned AW_B = 1;
    localparam int          DLY  = 5;   // SEND cycles before the sender answers
    localparam int          HOLD_A = 1;
    localparam int          HOLD_B = 3;

    logic clk;
    logic rst;
    logic inj_a;                        // pulse tx_done during FETCH on dut_a

    int n_total;
    int n_bad;
    int done_a;
    int done_b;
    int bytes_b;

    logic [7:0] mem_a [4];
    logic [7:0] mem_b [1];

    logic [7:0] pix_qa  [$];
    int         addr_qa [$];
    logic [7:0] pix_qb  [$];
    int         addr_qb [$];

    send_ctrl_if #(.AW(AW_A)) ifa ();
    send_ctrl_if #(.AW(AW_B)) ifb ();

    send_ctrl #(.NPIX(4), .AW(AW_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    send_ctrl #(.NPIX(1), .AW(AW_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // RAM models: data appears one cycle after rd_en, garbage otherwise.
    // ------------------------------------------------------------------------
    initial begin : ram_a
        logic            rq;
        logic [AW_A-1:0] ra;
        rq = 1'b0;
        ra = '0;
        ifa.rd_data = 8'hEE;
        forever begin
            @(negedge clk);
            rq = ifa.rd_en;
            ra = ifa.rd_addr;
            @(posedge clk);
            #1;
            ifa.rd_data = rq ? mem_a[ra[1:0]] : 8'hEE;
        end
    end

    initial begin : ram_b
        logic rq;
        rq = 1'b0;
        ifb.rd_data = 8'hEE;
        forever begin
            @(negedge clk);
            rq = ifb.rd_en;
            @(posedge clk);
            #1;
            ifb.rd_data = rq ? mem_b[0] : 8'hEE;
        end
    end

    // ------------------------------------------------------------------------
    // Sender models: answer DLY cycles into tx_we, hold tx_done HOLD cycles.
    // ------------------------------------------------------------------------
    initial begin : resp_a
        int wcnt;
        int hold;
        wcnt = 0;
        hold = 0;
        ifa.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ifa.tx_we) wcnt++;
            else wcnt = 0;
            if (wcnt == DLY) hold = HOLD_A;
            ifa.tx_done = (hold > 0) || (inj_a && ifa.rd_en);
            if (hold > 0) hold--;
        end
    end

    initial begin : resp_b
        int wcnt;
        int hold;
        wcnt = 0;
        hold = 0;
        ifb.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ifb.tx_we) wcnt++;
            else wcnt = 0;
            if (wcnt == DLY) hold = HOLD_B;
            ifb.tx_done = (hold > 0);
            if (hold > 0) hold--;
        end
    end

    // ------------------------------------------------------------------------
    // Monitors: pop expectations on each byte start / read strobe.
    // ------------------------------------------------------------------------
    initial begin : mon_a
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.tx_we && !prev) begin
                if (pix_qa.size() == 0) check_eq("a_pix_extra", 32'(pix_qa.size()), 32'd1);
                else check_eq("a_pix", 32'(ifa.tx_pixel), 32'(pix_qa.pop_front()));
            end
            if (ifa.rd_en) begin
                if (addr_qa.size() == 0) check_eq("a_addr_extra", 32'(addr_qa.size()), 32'd1);
                else check_eq("a_addr", 32'(ifa.rd_addr), 32'(addr_qa.pop_front()));
            end
            if (ifa.done) done_a++;
            prev = ifa.tx_we;
        end
    end

    initial begin : mon_b
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ifb.tx_we && !prev) begin
                bytes_b++;
                if (pix_qb.size() == 0) check_eq("b_pix_extra", 32'(pix_qb.size()), 32'd1);
                else check_eq("b_pix", 32'(ifb.tx_pixel), 32'(pix_qb.pop_front()));
            end
            if (ifb.rd_en) begin
                if (addr_qb.size() == 0) check_eq("b_addr_extra", 32'(addr_qb.size()), 32'd1);
                else check_eq("b_addr", 32'(ifb.rd_addr), 32'(addr_qb.pop_front()));
            end
            if (ifb.done) done_b++;
            prev = ifb.tx_we;
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic load_a(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
`ifdef SEND_CTRL_CHECKSUM_EN
        logic [7:0] s;
        s = d0 + d1 + d2 + d3;
`endif
        mem_a[0] = d0;
        mem_a[1] = d1;
        mem_a[2] = d2;
        mem_a[3] = d3;
        for (int i = 0; i < 4; i++) begin
            pix_qa.push_back(mem_a[i]);
            addr_qa.push_back(i);
        end
`ifdef SEND_CTRL_CHECKSUM_EN
        pix_qa.push_back(s);
`endif
    endtask

    // Returns at posedge+1 of the edge where the DUT enters FETCH.
    task automatic pulse_start_a();
        @(posedge clk);
        #1 ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(posedge clk);
        #1 ifb.start = 1'b1;
        @(posedge clk);
        #1 ifb.start = 1'b0;
    endtask

    task automatic wait_done_a(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (ifa.done) break;
        end
        check_eq(tag, 32'(ifa.done), 32'd1);
    endtask

    task automatic wait_done_b(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (ifb.done) break;
        end
        check_eq(tag, 32'(ifb.done), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        n_total   = 0;
        n_bad     = 0;
        done_a    = 0;
        done_b    = 0;
        bytes_b   = 0;
        rst       = 1'b1;
        inj_a     = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        mem_a     = '{8'h00, 8'h00, 8'h00, 8'h00};
        mem_b     = '{8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy",  32'(ifa.busy),     32'd0);
        check_eq("rst_done",  32'(ifa.done),     32'd0);
        check_eq("rst_rd_en", 32'(ifa.rd_en),    32'd0);
        check_eq("rst_addr",  32'(ifa.rd_addr),  32'd0);
        check_eq("rst_we",    32'(ifa.tx_we),    32'd0);
        check_eq("rst_pix",   32'(ifa.tx_pixel), 32'd0);
        check_eq("rst_b_busy", 32'(ifb.busy),    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame 1: nominal data plus start-to-send and byte-to-byte timing.
        load_a(8'h10, 8'h20, 8'h30, 8'h40);
        pulse_start_a();
        @(negedge clk);
        check_eq("t1_rd_en", 32'(ifa.rd_en), 32'd1);
        check_eq("t1_busy",  32'(ifa.busy),  32'd1);
        check_eq("t1_we",    32'(ifa.tx_we), 32'd0);
        @(negedge clk);
        check_eq("t2_we",    32'(ifa.tx_we), 32'd0);
        @(negedge clk);
        check_eq("t3_we",    32'(ifa.tx_we), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (ifa.tx_done) break;
            @(negedge clk);
        end
        check_eq("t_txdone_seen", 32'(ifa.tx_done), 32'd1);
        @(negedge clk);
        check_eq("gap_low",   32'(ifa.tx_we), 32'd0);
        @(negedge clk);
        check_eq("gap_fetch", 32'(ifa.rd_en), 32'd1);
        check_eq("gap_we1",   32'(ifa.tx_we), 32'd0);
        @(negedge clk);
        check_eq("gap_we2",   32'(ifa.tx_we), 32'd0);
        @(negedge clk);
        check_eq("gap_high",  32'(ifa.tx_we), 32'd1);
        wait_done_a(200, "f1_done_seen");
        repeat (2) @(negedge clk);
        check_eq("f1_done_cnt", 32'(done_a),         32'd1);
        check_eq("f1_pix_left", 32'(pix_qa.size()),  32'd0);
        check_eq("f1_adr_left", 32'(addr_qa.size()), 32'd0);
        check_eq("f1_idle",     32'(ifa.busy),       32'd0);

        // Frame 2: sum wraps mod 256 (0xFF+0x03+0xFE+0x02 = 0x202 -> 0x02);
        // tx_done pulsed during every FETCH and start pulsed while busy and
        // again coincident with DONE.
        load_a(8'hFF, 8'h03, 8'hFE, 8'h02);
        inj_a = 1'b1;
        pulse_start_a();
        repeat (6) @(posedge clk);
        #1 ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        wait_done_a(300, "f2_done_seen");
        ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        inj_a = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("f2_idle",     32'(ifa.busy),       32'd0);
        check_eq("f2_done_cnt", 32'(done_a),         32'd2);
        check_eq("f2_pix_left", 32'(pix_qa.size()),  32'd0);
        check_eq("f2_adr_left", 32'(addr_qa.size()), 32'd0);

        // Frame 3: reset while the first byte is on the wire.
        pix_qa.push_back(mem_a[0]);
        addr_qa.push_back(0);
        pulse_start_a();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifa.tx_we) break;
        end
        check_eq("rs_we_before", 32'(ifa.tx_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rs_we",    32'(ifa.tx_we), 32'd0);
        check_eq("rs_busy",  32'(ifa.busy),  32'd0);
        check_eq("rs_rd_en", 32'(ifa.rd_en), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rs_no_done",  32'(done_a),         32'd2);
        check_eq("rs_idle",     32'(ifa.busy),       32'd0);
        check_eq("rs_pix_left", 32'(pix_qa.size()),  32'd0);

        // Frame 4: NPIX=1 with tx_done held for three cycles.
        mem_b[0] = 8'h5A;
        pix_qb.push_back(8'h5A);
        addr_qb.push_back(0);
`ifdef SEND_CTRL_CHECKSUM_EN
        pix_qb.push_back(8'h5A);
`endif
        pulse_start_b();
        wait_done_b(100, "b_done_seen");
        repeat (4) @(negedge clk);
        check_eq("b_done_cnt", 32'(done_b),         32'd1);
`ifdef SEND_CTRL_CHECKSUM_EN
        check_eq("b_bytes",    32'(bytes_b),        32'd2);
`else
        check_eq("b_bytes",    32'(bytes_b),        32'd1);
`endif
        check_eq("b_pix_left", 32'(pix_qb.size()),  32'd0);
        check_eq("b_adr_left", 32'(addr_qb.size()), 32'd0);
        check_eq("b_addr_idx", 32'(ifb.rd_addr),    32'd0);
        check_eq("b_idle",     32'(ifb.busy),       32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

endmodule
